board_io: RTL and testbench

BOARD_IO -- requirements
Module: board_io

---
 rtl/board_io.sv | 148 ++++++++++++++
 tb/tb_board_io.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_io.sv
// ============================================================================
// board_io : debounced switch/button inputs with edge pulses, plus
//            period-synchronous multi-channel LED PWM with shadowed duties.
// Revision : 1.0
// ============================================================================
`default_nettype none

module board_io #(
  parameter  int N_IN      = 8,
  parameter  int DB_CYCLES = 1000,
  parameter  int N_PWM     = 15,
  parameter  int PWM_W     = 8,
  localparam int CHAN_W    = (N_PWM > 1) ? $clog2(N_PWM) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IN-1:0]   in_raw,
  output logic [N_IN-1:0]   in_stable,
  output logic [N_IN-1:0]   in_rise,
  output logic [N_IN-1:0]   in_fall,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CHAN_W-1:0] cfg_chan,
  input  logic [PWM_W-1:0]  cfg_duty,
  output logic [N_PWM-1:0]  pwm_out,
  output logic              period_tick
);

  localparam int              DB_W    = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Input synchronisers and per-bit debouncers
  // --------------------------------------------------------------------------
  logic [N_IN-1:0] sync1_q;
  logic [N_IN-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_raw;
      sync2_q <= sync1_q;
    end
  end

  generate
    for (genvar g = 0; g < N_IN; g++) begin : g_db
      logic [DB_W-1:0] cnt_q;
      logic [DB_W-1:0] cnt_d;
      logic            flip;
      logic            stable_q;
      logic            rise_q;
      logic            fall_q;

      // Counter runs only while the synchronised level disagrees with stable.
      always_comb begin
        cnt_d = '0;
        flip  = 1'b0;
        if (sync2_q[g] != stable_q) begin
          if (cnt_q == DB_LAST) begin
            flip = 1'b1;
          end else begin
            cnt_d = cnt_q + DB_W'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q    <= '0;
          stable_q <= 1'b0;
          rise_q   <= 1'b0;
          fall_q   <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          stable_q <= stable_q ^ flip;
          rise_q   <= flip & sync2_q[g];
          fall_q   <= flip & ~sync2_q[g];
        end
      end

      assign in_stable[g] = stable_q;
      assign in_rise[g]   = rise_q;
      assign in_fall[g]   = fall_q;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // PWM period counter and configuration port
  // --------------------------------------------------------------------------
  logic [PWM_W-1:0] pcnt_q;
  logic             tick_q;
  logic             wrap;
  logic             wr_en;

  assign cfg_ready   = ~reset;
  assign wr_en       = cfg_valid & cfg_ready;
  assign wrap        = (pcnt_q == '1);
  assign period_tick = tick_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_q + PWM_W'(1);
      tick_q <= (pcnt_q == '0);
    end
  end

  generate
    for (genvar c = 0; c < N_PWM; c++) begin : g_pwm
      logic             hit;
      logic [PWM_W-1:0] shadow_q;
      logic [PWM_W-1:0] shadow_d;
      logic [PWM_W-1:0] active_q;
      logic [PWM_W-1:0] active_d;
      logic             pwm_q;

      assign hit = wr_en && (cfg_chan == CHAN_W'(c));

      // Feeding active from shadow_d lets a write on the wrap cycle commit at once.
      always_comb begin
        shadow_d = hit ? cfg_duty : shadow_q;
        active_d = wrap ? shadow_d : active_q;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          shadow_q <= '0;
          active_q <= '0;
          pwm_q    <= 1'b0;
        end else begin
          shadow_q <= shadow_d;
          active_q <= active_d;
          pwm_q    <= (pcnt_q < active_q);
        end
      end

      assign pwm_out[c] = pwm_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_board_io.sv
// ============================================================================
// tb_board_io : scoreboard bench for board_io (debounce events, PWM periods).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_board_io;

  localparam int N_IN   = 8;
  localparam int DB     = 4;
  localparam int N_PWM  = 15;
  localparam int PWM_W  = 4;
  localparam int CHAN_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N_IN-1:0]   in_raw;
  logic [N_IN-1:0]   in_stable;
  logic [N_IN-1:0]   in_rise;
  logic [N_IN-1:0]   in_fall;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CHAN_W-1:0] cfg_chan;
  logic [PWM_W-1:0]  cfg_duty;
  logic [N_PWM-1:0]  pwm_out;
  logic              period_tick;

  board_io #(
    .N_IN(N_IN), .DB_CYCLES(DB), .N_PWM(N_PWM), .PWM_W(PWM_W)
  ) dut (
    .clk(clk), .reset(reset), .in_raw(in_raw),
    .in_stable(in_stable), .in_rise(in_rise), .in_fall(in_fall),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_duty(cfg_duty),
    .pwm_out(pwm_out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int              cyc;
    logic [N_IN-1:0] rise;
    logic [N_IN-1:0] fall;
    logic [N_IN-1:0] stable;
  } ev_t;

  typedef struct {
    int                       idx;
    logic [N_PWM*PWM_W-1:0]   duty;
  } per_t;

  ev_t  evq[$];
  per_t pq[$];
  ev_t  mon_e;
  per_t mon_p;
  int   pidx = -1;
  logic [4:0]       hi_cnt [N_PWM];
  logic [N_PWM-1:0] first_bits;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected debounce events and per-period PWM profiles.
  always @(negedge clk) begin
    if ((in_rise | in_fall) != '0) begin
      if (evq.size() == 0) begin
        chk("unexpected_edge_event", {in_rise, in_fall}, 64'h0);
      end else begin
        mon_e = evq.pop_front();
        chk("ev_cycle",  64'(cyc),   64'(mon_e.cyc));
        chk("ev_rise",   in_rise,    mon_e.rise);
        chk("ev_fall",   in_fall,    mon_e.fall);
        chk("ev_stable", in_stable,  mon_e.stable);
      end
    end
    if (period_tick === 1'b1) begin
      if (pidx >= 0 && pq.size() > 0 && pq[0].idx == pidx) begin
        mon_p = pq.pop_front();
        for (int ch = 0; ch < N_PWM; ch++) begin
          chk($sformatf("pwm_p%0d_ch%0d_count_first", pidx, ch),
              {hi_cnt[ch], first_bits[ch]},
              {1'b0, mon_p.duty[ch*PWM_W +: PWM_W], mon_p.duty[ch*PWM_W +: PWM_W] != '0});
        end
      end
      pidx++;
      first_bits = pwm_out;
      for (int ch = 0; ch < N_PWM; ch++) hi_cnt[ch] = 5'(pwm_out[ch]);
    end else begin
      for (int ch = 0; ch < N_PWM; ch++) hi_cnt[ch] = hi_cnt[ch] + 5'(pwm_out[ch]);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_ev(input int c, input logic [N_IN-1:0] r, input logic [N_IN-1:0] f,
                         input logic [N_IN-1:0] s);
    ev_t e;
    e.cyc = c; e.rise = r; e.fall = f; e.stable = s;
    evq.push_back(e);
  endtask

  task automatic push_per(input int idx, input logic [N_PWM*PWM_W-1:0] d);
    per_t p;
    p.idx = idx; p.duty = d;
    pq.push_back(p);
  endtask

  task automatic write(input int ch, input int d);
    cfg_valid = 1'b1;
    cfg_chan  = CHAN_W'(ch);
    cfg_duty  = PWM_W'(d);
    chk("cfg_ready_on_write", cfg_ready, 1);
    step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (period_tick) begin
        seen = 1'b1;
        break;
      end
    end
    chk("period_tick_seen", seen, 1);
  endtask

  task automatic wait_pidx(input int target);
    for (int i = 0; i < 200 && pidx < target; i++) step(1);
    chk("period_index_reached", pidx >= target, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_PWM*PWM_W-1:0] dv;
    int e1;
    int p0;
    reset = 1'b1; in_raw = '0; cfg_valid = 1'b0; cfg_chan = '0; cfg_duty = '0;
    step(2);
    chk("rst_in_stable",   in_stable,   0);
    chk("rst_in_rise",     in_rise,     0);
    chk("rst_in_fall",     in_fall,     0);
    chk("rst_pwm_out",     pwm_out,     0);
    chk("rst_period_tick", period_tick, 0);
    chk("rst_cfg_ready",   cfg_ready,   0);
    reset = 1'b0;
    #1;
    chk("cfg_ready_after_release", cfg_ready, 1);
    step(1);

    // Held rise on bit 0: update DB+2 edges after drive.
    in_raw = 8'h01; push_ev(cyc + DB + 2, 8'h01, 8'h00, 8'h01); step(10);
    // 3-cycle glitch on bit 1: no event.
    in_raw = 8'h03; step(3); in_raw = 8'h01; step(12);
    // Exactly DB-cycle excursion on bit 1: accepted, then returns.
    e1 = cyc;
    in_raw = 8'h03; push_ev(e1 + 6, 8'h02, 8'h00, 8'h03);
    step(4);
    in_raw = 8'h01; push_ev(e1 + 10, 8'h00, 8'h02, 8'h01);
    step(12);
    // Simultaneous fall on bit 0 and rises on bits 2,3.
    in_raw = 8'h0c; push_ev(cyc + 6, 8'h0c, 8'h01, 8'h0c); step(10);
    chk("ev_queue_drained_1", 64'(evq.size()), 0);

    // PWM: mid-period writes take effect from the next period.
    wait_tick();
    p0 = pidx + 1;
    step(3);
    dv = '0;
    push_per(p0, dv);
    dv[2*PWM_W +: PWM_W] = 4'd5;
    dv[5*PWM_W +: PWM_W] = 4'd15;
    push_per(p0 + 1, dv);
    write(2, 5); write(5, 15); write(6, 0);

    // Two writes to ch1 in one period plus a write to a nonexistent channel.
    wait_tick();
    dv[1*PWM_W +: PWM_W] = 4'd7;
    push_per(p0 + 2, dv);
    step(2); write(1, 3); step(3); write(1, 7); step(1); write(15, 12);

    // Write on the exact wrap cycle bypasses, the next cycle waits a period.
    wait_tick();
    dv[1*PWM_W +: PWM_W] = 4'd9;
    push_per(p0 + 3, dv);
    dv[2*PWM_W +: PWM_W] = 4'd0;
    push_per(p0 + 4, dv);
    step(14); write(1, 9); write(2, 0);
    wait_pidx(p0 + 5);

    // Reset mid-period with all inputs high.
    step(5);
    in_raw = 8'hff; reset = 1'b1;
    step(1);
    chk("rst2_in_stable",   in_stable,   0);
    chk("rst2_in_rise",     in_rise,     0);
    chk("rst2_in_fall",     in_fall,     0);
    chk("rst2_pwm_out",     pwm_out,     0);
    chk("rst2_period_tick", period_tick, 0);
    chk("rst2_cfg_ready",   cfg_ready,   0);
    step(2);
    reset = 1'b0;
    push_ev(cyc + DB + 2, 8'hff, 8'h00, 8'hff);
    wait_tick();
    p0 = pidx + 1;
    push_per(p0, '0);
    wait_pidx(p0 + 1);
    step(5);
    chk("ev_queue_drained_2",  64'(evq.size()), 0);
    chk("pwm_queue_drained",   64'(pq.size()),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
